mac_out_packer: RTL and testbench

MAC_OUT_PACKER -- requirements
Module: mac_out_packer

---
 rtl/mac_out_packer_if.sv | 18 +
 rtl/mac_out_packer.sv | 258 +++++++++++++++++++++++++
 tb/tb_mac_out_packer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_out_packer_if.sv
// ---------------------------------------------------------------------------
// hwpe_stream_intf_stream: minimal valid/ready streaming interface used by
// mac_out_packer for its input element stream and its packed output stream.
//   valid : producer has a beat on data
//   ready : consumer accepts the beat this cycle
//   data  : DATA_WIDTH-bit payload
// Modports: source (producer side), sink (consumer side).
// ---------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport source (output valid, output data, input ready);
    modport sink   (input valid, input data, output ready);
endinterface

// File: rtl/mac_out_packer.sv
// ---------------------------------------------------------------------------
// mac_out_packer
// Takes signed 32-bit MAC results, applies an arithmetic right shift and
// saturates them to a selectable lane width (32/16/8 bit), then packs the
// lanes little-endian into 32-bit output words. A job of len_i elements is
// started with start_i; done_o pulses once the last word has been taken.
//
// Optional feature: define MAC_OUT_PACKER_ROUND_EN to round half up before
// the shift (adds 2^(shift-1) in 33-bit arithmetic). Default truncates.
//
// Ports:
//   clk_i, rst_ni (async, active-low), clear_i (sync clear, top priority)
//   enable_i  : global enable, all state held while low
//   start_i   : job start pulse (only honoured in IDLE)
//   len_i     : number of input elements in the job
//   shift_i   : arithmetic right-shift amount
//   width_i   : lane width, 0 = 32b, 1 = 16b, 2/3 = 8b
//   d_i       : input element stream (sink)
//   q_o       : packed output word stream (source)
//   busy_o    : job in progress
//   done_o    : one-cycle pulse at job end
//   cnt_o     : elements accepted in the current job
// ---------------------------------------------------------------------------
module mac_out_packer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LANE_SEL_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic [4:0]            shift_i,
    input  logic [LANE_SEL_W-1:0] width_i,
    hwpe_stream_intf_stream.sink  d_i,
    hwpe_stream_intf_stream.source q_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [4:0]            shift_q, shift_d;
    logic [LANE_SEL_W-1:0] width_q, width_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           pack_q, pack_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;

    logic signed [32:0]    ext_s, rnd_s, shd_s;
    logic [31:0]           lane_s, word_s;
    logic                  elem_last_s, word_full_s, d_ready_s;
    logic                  accept_s, q_valid_s, q_hs_s;

    // Shift (with optional rounding) and saturation of the incoming element.
    always_comb begin
        ext_s = {d_i.data[31], d_i.data};
`ifdef MAC_OUT_PACKER_ROUND_EN
        if (shift_q != 5'd0) begin
            rnd_s = 33'sd1 <<< (shift_q - 5'd1);
        end else begin
            rnd_s = 33'sd0;
        end
`else
        rnd_s = 33'sd0;
`endif
        // 33 bits hold any 32-bit input plus 2^30 without overflow.
        shd_s = (ext_s + rnd_s) >>> shift_q;
        if (width_q == LANE_SEL_W'(0)) begin
            lane_s = shd_s[31:0];
        end else if (width_q == LANE_SEL_W'(1)) begin
            if (shd_s > 33'sd32767) begin
                lane_s = 32'h0000_7FFF;
            end else if (shd_s < -33'sd32768) begin
                lane_s = 32'hFFFF_8000;
            end else begin
                lane_s = shd_s[31:0];
            end
        end else begin
            if (shd_s > 33'sd127) begin
                lane_s = 32'h0000_007F;
            end else if (shd_s < -33'sd128) begin
                lane_s = 32'hFFFF_FF80;
            end else begin
                lane_s = shd_s[31:0];
            end
        end
    end

    // Lane insertion and word-completion detection.
    always_comb begin
        word_s      = 32'h0000_0000;
        word_full_s = 1'b0;
        elem_last_s = ((cnt_q + CNT_W'(1)) == len_q);
        case (width_q)
            LANE_SEL_W'(0): begin
                word_s      = lane_s;
                word_full_s = 1'b1;
            end
            LANE_SEL_W'(1): begin
                word_s      = lane_q[0] ? {lane_s[15:0], pack_q[15:0]}
                                        : {16'h0000, lane_s[15:0]};
                word_full_s = lane_q[0] | elem_last_s;
            end
            default: begin
                case (lane_q)
                    2'd0:    word_s = {24'h000000, lane_s[7:0]};
                    2'd1:    word_s = {16'h0000, lane_s[7:0], pack_q[7:0]};
                    2'd2:    word_s = {8'h00, lane_s[7:0], pack_q[15:0]};
                    default: word_s = {lane_s[7:0], pack_q[23:0]};
                endcase
                word_full_s = (lane_q == 2'd3) | elem_last_s;
            end
        endcase
    end

    // An element that completes a word may only enter when the output
    // register is free or being emptied in the same cycle.
    assign d_ready_s = (state_q == RUN) & enable_i &
                       (~word_full_s | ~out_valid_q | q_o.ready);
    assign accept_s  = d_i.valid & d_ready_s;
    assign q_valid_s = out_valid_q & enable_i;
    assign q_hs_s    = q_valid_s & q_o.ready;

    assign d_i.ready = d_ready_s;
    assign q_o.valid = q_valid_s;
    assign q_o.data  = out_data_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign cnt_o     = cnt_q;

    // Job control FSM, counter and packing register next-state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        shift_d = shift_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && start_i) begin
                    len_d   = len_i;
                    shift_d = shift_i;
                    width_d = width_i;
                    cnt_d   = {CNT_W{1'b0}};
                    pack_d  = 32'h0000_0000;
                    lane_d  = 2'd0;
                    if (len_i == {CNT_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    if (cnt_q != len_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (word_full_s) begin
                        pack_d = 32'h0000_0000;
                        lane_d = 2'd0;
                    end else begin
                        pack_d = word_s;
                        lane_d = lane_q + 2'd1;
                    end
                    if (elem_last_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Only the final word can be in the output register here.
                if (q_hs_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept_s && word_full_s) begin
            out_data_d  = word_s;
            out_valid_d = 1'b1;
        end else if (q_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with async reset and synchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            len_q       <= {CNT_W{1'b0}};
            shift_q     <= 5'd0;
            width_q     <= {LANE_SEL_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            pack_q      <= 32'h0000_0000;
            lane_q      <= 2'd0;
            out_data_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            len_q       <= {CNT_W{1'b0}};
            shift_q     <= 5'd0;
            width_q     <= {LANE_SEL_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            pack_q      <= 32'h0000_0000;
            lane_q      <= 2'd0;
            out_data_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            width_q     <= width_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_out_packer.sv
module tb_mac_out_packer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = 16'd0;
    logic [4:0]  shift = 5'd0;
    logic [1:0]  width = 2'd0;
    logic        d_valid = 1'b0;
    logic [31:0] d_data = 32'd0;
    logic        q_ready = 1'b1;
    logic        busy, done;
    logic [15:0] cnt;
    logic        rnd_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) q_if ();

    assign d_if.valid = d_valid;
    assign d_if.data  = d_data;
    assign q_if.ready = q_ready;

    mac_out_packer #(.CNT_W(16), .LANE_SEL_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .enable_i(enable),
        .start_i(start), .len_i(len), .shift_i(shift), .width_i(width),
        .d_i(d_if), .q_o(q_if),
        .busy_o(busy), .done_o(done), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor / scoreboard: every output handshake is matched against the queue.
    always @(negedge clk) begin
        if (q_if.valid === 1'b1 && q_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", q_if.data);
            end else begin
                check("q_word", q_if.data, exp_q.pop_front());
            end
        end
    end

    // Random back-pressure on q_o.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 q_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Reference: shift (optionally rounded), saturate, return lane value.
    function automatic longint ref_elem(input logic [31:0] x, input int sh, input int w);
        longint v;
        v = longint'($signed(x));
`ifdef MAC_OUT_PACKER_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        v = v >>> sh;
        if (w == 1) begin
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
        end else if (w >= 2) begin
            if (v > 127) v = 127;
            if (v < -128) v = -128;
        end
        return v;
    endfunction

    // Reference: pack a job's elements into expected words and queue them.
    task automatic push_expected(input logic [31:0] el[$], input int sh, input int w);
        int nl, lw, k;
        longint acc, mask;
        logic [63:0] tmp;
        nl = (w == 0) ? 1 : ((w == 1) ? 2 : 4);
        lw = 32 / nl;
        mask = (longint'(1) << lw) - 1;
        acc = 0;
        k = 0;
        for (int i = 0; i < el.size(); i++) begin
            acc = acc | ((ref_elem(el[i], sh, w) & mask) << (k * lw));
            k++;
            if (k == nl || i == el.size() - 1) begin
                tmp = acc;
                exp_q.push_back(tmp[31:0]);
                acc = 0;
                k = 0;
            end
        end
    endtask

    task automatic start_job(input int l, input int sh, input int w);
        start = 1'b1;
        len = l[15:0];
        shift = sh[4:0];
        width = w[1:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        d_valid = 1'b1;
        d_data = x;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (d_if.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        @(posedge clk);
        #1 d_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL d_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [31:0] el[$], input int sh, input int w);
        int wt;
        push_expected(el, sh, w);
        start_job(el.size(), sh, w);
        foreach (el[i]) send(el[i], wt);
        wait_done();
        check("cnt_at_done", {16'd0, cnt}, el.size());
    endtask

    initial begin
        logic [31:0] el[$];
        logic [31:0] w1;
        int wt;

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cnt", {16'd0, cnt}, 32'd0);
        check("rst_qvalid", {31'd0, q_if.valid}, 32'd0);
        check("rst_dready", {31'd0, d_if.ready}, 32'd0);
        @(posedge clk);
        #1;

        // 8b lanes with saturation: one word 0x807FFF01.
        exp_q.push_back(32'h807F_FF01);
        start_job(4, 0, 2);
        send(32'd1, wt); send(32'hFFFF_FFFF, wt); send(32'd200, wt); send(-32'sd300, wt);
        wait_done();

        // 16b lanes, shift 4, partial final word.
        exp_q.push_back(32'h7FFF_0010);
        exp_q.push_back(32'h0000_FFFF);
        start_job(3, 4, 1);
        send(32'h0000_0100, wt); send(32'h0007_FFFF, wt); send(-32'sd16, wt);
        wait_done();

        // Rounding option, 32b lanes, shift 1, input 3.
`ifdef MAC_OUT_PACKER_ROUND_EN
        exp_q.push_back(32'd2);
`else
        exp_q.push_back(32'd1);
`endif
        start_job(1, 1, 0);
        send(32'd3, wt);
        wait_done();

        // Output back-pressure mid-job.
        el = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd5, 32'd6, 32'd7, 32'd8};
        push_expected(el, 0, 2);
        w1 = 32'h281E_140A;
        start_job(8, 0, 2);
        for (int i = 0; i < 4; i++) send(el[i], wt);
        q_ready = 1'b0;
        for (int i = 4; i < 7; i++) begin
            send(el[i], wt);
            check("stall_accept_wait", wt, 32'd0);
        end
        d_valid = 1'b1;
        d_data = el[7];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_dready", {31'd0, d_if.ready}, 32'd0);
            check("stall_qvalid", {31'd0, q_if.valid}, 32'd1);
            check("stall_qdata", q_if.data, w1);
            @(posedge clk);
            #1;
        end
        q_ready = 1'b1;
        send(el[7], wt);
        wait_done();

        // len = 0 start.
        start_job(0, 0, 0);
        @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_qvalid", {31'd0, q_if.valid}, 32'd0);
        @(negedge clk);
        check("len0_done_pulse", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        // Start while busy is ignored.
        el = '{32'h1234_5678, 32'h8000_0001};
        push_expected(el, 0, 0);
        start_job(2, 0, 0);
        start_job(5, 3, 2);
        send(el[0], wt); send(el[1], wt);
        wait_done();
        check("busy_start_cnt", {16'd0, cnt}, 32'd2);

        // Clear after 2 of 4 elements in 8b mode.
        start_job(4, 0, 2);
        send(32'd1, wt); send(32'd2, wt);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_cnt", {16'd0, cnt}, 32'd0);
        check("clr_qvalid", {31'd0, q_if.valid}, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Randomized jobs under random back-pressure.
        rnd_ready = 1'b1;
        for (int j = 0; j < 25; j++) begin
            int l, sh, w, kind;
            l = $urandom_range(1, 9);
            sh = $urandom_range(0, 31);
            w = $urandom_range(0, 3);
            el = {};
            for (int i = 0; i < l; i++) begin
                kind = $urandom_range(0, 2);
                if (kind == 0) el.push_back($urandom);
                else if (kind == 1) el.push_back(32'($signed($urandom_range(0, 600)) - 300));
                else el.push_back(32'($signed($urandom_range(0, 140000)) - 70000));
            end
            if ($urandom_range(0, 1) == 1) sh = $urandom_range(0, 4);
            run_job(el, sh, w);
        end
        rnd_ready = 1'b0;
        #2 q_ready = 1'b1;
        repeat (20) @(posedge clk);
        check("leftover_expected", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
